mult_seq_signed: RTL and testbench

//   Sequential radix-2 shift-add multiplier for signed two's-complement operands.
//   - Converts each operand to magnitude with a two's-complement negate.
//   - Multiplies the unsigned magnitudes, one bit per clock.
//   - Re-applies the sign by negating the result.

---
 rtl/mult_seq_signed_if.sv | 35 +++
 rtl/mult_seq_signed.sv | 114 +++++++++++
 tb/tb_mult_seq_signed.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_signed_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_signed_if
// Description : Request/response bundle for the sequential signed multiplier.
//               master drives start/a_in/b_in and observes busy/done/product;
//               slave is the multiplier side.
//   start    master->slave  1          request, sampled only while idle
//   a_in     master->slave  WIDTH      multiplicand, two's complement
//   b_in     master->slave  WIDTH      multiplier, two's complement
//   busy     slave->master  1          operation in flight
//   done     slave->master  1          one-cycle pulse, product valid
//   product  slave->master  2*WIDTH    signed product, held between completions
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_seq_signed_if #(
    parameter int WIDTH = 10
) ();
    logic                 start;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a_in, b_in,
        input  busy, done, product
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/mult_seq_signed.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_signed
// Description : Radix-2 shift-add multiplier for signed two's-complement
//               operands. Operands are reduced to magnitudes at acceptance,
//               the magnitudes are multiplied one bit per clock, and the sign
//               is re-applied in a final cycle. Latency WIDTH+1 cycles.
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   bus     slave modport of mult_seq_signed_if (start/a_in/b_in in,
//           busy/done/product out)
// Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_signed #(
    parameter int WIDTH = 10
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mult_seq_signed_if.slave    bus
);

    localparam int              CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] c_ONE_P  = (2*WIDTH)'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_SIGN = 2'd2;

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic                 r_neg;
    logic [2*WIDTH:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_mag_a_in;
    logic [WIDTH-1:0]     w_mag_b_in;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_upper;
    logic [2*WIDTH:0]     w_acc_next;
    logic [2*WIDTH-1:0]   w_signed_prod;

    // Most-negative input negates to itself, which read as unsigned is the
    // correct magnitude 2^(WIDTH-1).
    assign w_mag_a_in = bus.a_in[WIDTH-1] ? (~bus.a_in + c_ONE_W) : bus.a_in;
    assign w_mag_b_in = bus.b_in[WIDTH-1] ? (~bus.b_in + c_ONE_W) : bus.b_in;

    // Partial-product add into the upper WIDTH+1 bits so the carry survives
    // the following right shift.
    assign w_sum      = r_acc[2*WIDTH:WIDTH] + {1'b0, r_mag_a};
    assign w_upper    = r_mag_b[0] ? w_sum : r_acc[2*WIDTH:WIDTH];
    assign w_acc_next = {1'b0, w_upper, r_acc[WIDTH-1:1]};

    assign w_signed_prod = r_neg ? (~r_acc[2*WIDTH-1:0] + c_ONE_P)
                                 : r_acc[2*WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_mag_a <= w_mag_a_in;
                        r_mag_b <= w_mag_b_in;
                        r_neg   <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_mag_b <= r_mag_b >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_SIGN;
                    end
                end
                c_ST_SIGN: begin
                    r_product <= w_signed_prod;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_signed.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_seq_signed
// Description : Self-checking bench for mult_seq_signed (WIDTH=10). Expected
//               products come from plain signed integer multiplication.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq_signed;

    localparam int WIDTH = 10;
    localparam int PW    = 2 * WIDTH;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mult_seq_signed_if #(.WIDTH(WIDTH)) bus ();

    mult_seq_signed #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [PW-1:0] last_prod = '0;

    function automatic logic [PW-1:0] ref_mul(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        longint sa;
        longint sb;
        longint p;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        return p[PW-1:0];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done; cyc = edges elapsed, checked by caller.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done === 1'b1) break;
        end
    endtask

    task automatic issue(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        // Operands must have been captured; scramble them.
        bus.a_in  = WIDTH'($urandom);
        bus.b_in  = WIDTH'($urandom);
    endtask

    task automatic run_op(string tag, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        int            cyc;
        logic [PW-1:0] exp;
        exp = ref_mul(a, b);
        issue(a, b);
        chk({tag, "_busy_hi"}, 64'(bus.busy), 64'(1));
        chk({tag, "_prod_held"}, 64'(bus.product), 64'(last_prod));
        wait_done(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'(WIDTH + 1));
        chk({tag, "_product"}, 64'(bus.product), 64'(exp));
        chk({tag, "_busy_lo"}, 64'(bus.busy), 64'(0));
        last_prod = exp;
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
        chk({tag, "_prod_keep"}, 64'(bus.product), 64'(last_prod));
    endtask

    initial begin
        int            cyc;
        int            n_done;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [PW-1:0] exp;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_prod", 64'(bus.product), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("t1_3x5",      10'd3,     10'd5);
        run_op("t2_m7x6",     10'h3F9,   10'd6);
        run_op("t3_minxmin",  10'h200,   10'h200);
        run_op("t3_minxmax",  10'h200,   10'h1FF);
        run_op("t4_0xm1",     10'd0,     10'h3FF);
        run_op("t4_m1xm1",    10'h3FF,   10'h3FF);
        chk("t1_value", 64'(ref_mul(10'd3, 10'd5)), 64'h0000F);

        // Start while busy is ignored; start in the done cycle is accepted.
        exp = ref_mul(10'd25, 10'h3F0);
        issue(10'd25, 10'h3F0);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a_in  = 10'd100;
        bus.b_in  = 10'd100;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc);
        chk("t5_ignore_done", 64'(bus.done), 64'(1));
        chk("t5_ignore_prod", 64'(bus.product), 64'(exp));
        last_prod = exp;
        bus.start = 1'b1;
        bus.a_in  = 10'h3E0;
        bus.b_in  = 10'd17;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("t5_b2b_busy", 64'(bus.busy), 64'(1));
        chk("t5_b2b_prod_held", 64'(bus.product), 64'(last_prod));
        wait_done(cyc);
        chk("t5_b2b_latency", 64'(cyc), 64'(WIDTH + 1));
        exp = ref_mul(10'h3E0, 10'd17);
        chk("t5_b2b_prod", 64'(bus.product), 64'(exp));
        last_prod = exp;
        @(posedge clk);
        #1;

        // Reset mid-operation
        issue(10'd123, 10'h345);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(bus.busy), 64'(0));
        chk("t6_rst_done", 64'(bus.done), 64'(0));
        chk("t6_rst_prod", 64'(bus.product), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) n_done++;
        end
        chk("t6_no_done", 64'(n_done), 64'(0));
        last_prod = '0;
        run_op("t6_after", 10'h2AB, 10'd77);

        // Randomized operands against the integer model
        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
